regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, requester count and requester identities for the writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int N_REQ_DEF  = 3;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_CSR  = 2'd2
    } req_idx_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant search starting at ptr, wrapping modulo N_REQ.
// Latency: combinational.
// Backpressure: only one requester is granted; the rest wait for a later cycle.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grantIdx,
    output logic             any
);

    int idx;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        any      = 1'b0;
        idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grantIdx   = PTR_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter into the register file plus a RAW-hazard scoreboard.
// Latency: grant in cycle t drives RegWrite/writeReg/writeData in t+1.
// Backpressure: ungranted requesters see reqReady=0 and must hold their request.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic [N_REQ-1:0]              reqValid,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  reqReg,
    input  logic [N_REQ-1:0][DATA_W-1:0]  reqData,
    output logic [N_REQ-1:0]              reqReady,
    output logic                          RegWrite,
    output logic [ADDR_W-1:0]             writeReg,
    output logic [DATA_W-1:0]             writeData,
    input  logic                          claimValid,
    input  logic [ADDR_W-1:0]             claimReg,
    input  logic [ADDR_W-1:0]             readReg1,
    input  logic [ADDR_W-1:0]             readReg2,
    output logic                          stall
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int N_REGS = 1 << ADDR_W;

    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  grantIdx;
    logic [N_REQ-1:0]  grant;
    logic              grantAny;
    logic [ADDR_W-1:0] selReg;
    logic [DATA_W-1:0] selData;
    logic [N_REGS-1:0] pending;
    logic [N_REGS-1:0] pendingNxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) uArb (
        .req      (reqValid),
        .ptr      (rrPtr),
        .grant    (grant),
        .grantIdx (grantIdx),
        .any      (grantAny)
    );

    // Grants are suppressed while reset is held so no requester sees a transfer.
    assign reqReady = grant & {N_REQ{RST_n}};
    assign selReg   = reqReg[grantIdx];
    assign selData  = reqData[grantIdx];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rrPtr <= '0;
        end else if (grantAny) begin
            if (grantIdx == PTR_W'(N_REQ - 1))
                rrPtr <= '0;
            else
                rrPtr <= grantIdx + PTR_W'(1);
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            RegWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else if (grantAny && selReg != '0) begin
            RegWrite  <= 1'b1;
            writeReg  <= selReg;
            writeData <= selData;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // A claim landing on the register being committed wins over the clear.
    always_comb begin
        pendingNxt = pending;
        if (RegWrite)
            pendingNxt[writeReg] = 1'b0;
        if (claimValid && claimReg != '0)
            pendingNxt[claimReg] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            pending <= '0;
        else
            pending <= pendingNxt;
    end

    assign stall = pending[readReg1] | pending[readReg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration vector table, then hazard and reset sequences.
module tb_regfile_wb_arbiter;

    logic            CLK;
    logic            RST_n;
    logic [2:0]      reqValid;
    logic [2:0][4:0] reqReg;
    logic [2:0][31:0] reqData;
    logic [2:0]      reqReady;
    logic            RegWrite;
    logic [4:0]      writeReg;
    logic [31:0]     writeData;
    logic            claimValid;
    logic [4:0]      claimReg;
    logic [4:0]      readReg1;
    logic [4:0]      readReg2;
    logic            stall;

    int total;
    int bad;

    logic [31:0] rf [32];

    regfile_wb_arbiter dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .reqValid   (reqValid),
        .reqReg     (reqReg),
        .reqData    (reqData),
        .reqReady   (reqReady),
        .RegWrite   (RegWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .claimValid (claimValid),
        .claimReg   (claimReg),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .stall      (stall)
    );

    always #5 CLK = ~CLK;

    // Consumer-side register file, filled from the write port.
    always @(posedge CLK) begin
        if (RegWrite)
            rf[writeReg] <= writeData;
    end

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  expReady;
        logic        expWr;
        logic [4:0]  expReg;
        logic [31:0] expData;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int r = 0; r < 32; r++) rf[r] = '0;
        CLK        = 1'b0;
        RST_n      = 1'b0;
        claimValid = 1'b0;
        claimReg   = '0;
        readReg1   = 5'd0;
        readReg2   = 5'd0;
        reqReg[0]  = 5'd1;  reqData[0] = 32'h111;
        reqReg[1]  = 5'd2;  reqData[1] = 32'h222;
        reqReg[2]  = 5'd3;  reqData[2] = 32'h333;
        reqValid   = 3'b111;

        vec[0]  = '{3'b111, 3'b001, 1'b0, 5'd0, 32'h0};
        vec[1]  = '{3'b111, 3'b010, 1'b1, 5'd1, 32'h111};
        vec[2]  = '{3'b111, 3'b100, 1'b1, 5'd2, 32'h222};
        vec[3]  = '{3'b111, 3'b001, 1'b1, 5'd3, 32'h333};
        vec[4]  = '{3'b000, 3'b000, 1'b1, 5'd1, 32'h111};
        vec[5]  = '{3'b101, 3'b100, 1'b0, 5'd1, 32'h111};
        vec[6]  = '{3'b100, 3'b100, 1'b1, 5'd3, 32'h333};
        vec[7]  = '{3'b001, 3'b001, 1'b1, 5'd3, 32'h333};
        vec[8]  = '{3'b011, 3'b010, 1'b1, 5'd1, 32'h111};
        vec[9]  = '{3'b000, 3'b000, 1'b1, 5'd2, 32'h222};
        vec[10] = '{3'b100, 3'b100, 1'b0, 5'd2, 32'h222};
        vec[11] = '{3'b000, 3'b000, 1'b1, 5'd3, 32'h333};
        vec[12] = '{3'b000, 3'b000, 1'b0, 5'd3, 32'h333};

        // Reset state with every requester asking.
        @(negedge CLK); #2;
        chk("rst_ready",     32'(reqReady),  32'h0);
        chk("rst_regwrite",  32'(RegWrite),  32'h0);
        chk("rst_writereg",  32'(writeReg),  32'h0);
        chk("rst_writedata", writeData,      32'h0);
        chk("rst_stall",     32'(stall),     32'h0);
        @(negedge CLK);
        reqValid = 3'b000;
        RST_n    = 1'b1;

        // Round-robin table: reqReady now, write port from the previous cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            reqValid = vec[i].valid;
            #2;
            chk($sformatf("v%0d_ready", i),    32'(reqReady), 32'(vec[i].expReady));
            chk($sformatf("v%0d_regwrite", i), 32'(RegWrite), 32'(vec[i].expWr));
            chk($sformatf("v%0d_writereg", i), 32'(writeReg), 32'(vec[i].expReg));
            chk($sformatf("v%0d_writedata", i), writeData,    vec[i].expData);
        end

        // Claim x5, LOAD commits it two cycles later; ungranted ALU data wiggles.
        @(negedge CLK);
        claimValid = 1'b1; claimReg = 5'd5; readReg1 = 5'd5;
        #2;
        chk("raw_stall_before_claim", 32'(stall), 32'h0);
        @(negedge CLK);
        claimValid = 1'b0;
        #2;
        chk("raw_stall_claimed", 32'(stall), 32'h1);
        @(negedge CLK);
        reqReg[1] = 5'd5; reqData[1] = 32'hDEADBEEF; reqValid = 3'b010;
        reqData[0] = 32'hBAD0BAD0;
        #2;
        chk("raw_load_ready", 32'(reqReady), 32'h2);
        chk("raw_stall_grant", 32'(stall), 32'h1);
        @(negedge CLK);
        reqValid = 3'b000;
        #2;
        chk("raw_regwrite",  32'(RegWrite), 32'h1);
        chk("raw_writereg",  32'(writeReg), 32'h5);
        chk("raw_writedata", writeData,     32'hDEADBEEF);
        chk("raw_stall_commit", 32'(stall), 32'h1);
        @(negedge CLK); #2;
        chk("raw_stall_cleared", 32'(stall), 32'h0);
        chk("raw_regwrite_off",  32'(RegWrite), 32'h0);
        chk("raw_rf_x5", rf[5], 32'hDEADBEEF);

        // ALU write to x0 is accepted and dropped (pointer is at 2).
        @(negedge CLK);
        reqReg[0] = 5'd0; reqData[0] = 32'h1234; reqValid = 3'b001;
        readReg1 = 5'd0; readReg2 = 5'd5;
        #2;
        chk("x0_ready", 32'(reqReady), 32'h1);
        @(negedge CLK);
        reqValid = 3'b000;
        #2;
        chk("x0_regwrite", 32'(RegWrite), 32'h0);
        chk("x0_stall",    32'(stall),    32'h0);

        // Claim x7 in the same cycle x7 commits: the claim survives.
        @(negedge CLK);
        reqReg[0] = 5'd7; reqData[0] = 32'h77; reqValid = 3'b001;
        readReg2 = 5'd7;
        #2;
        chk("setwin_ready", 32'(reqReady), 32'h1);
        chk("setwin_stall_pre", 32'(stall), 32'h0);
        @(negedge CLK);
        reqValid = 3'b000; claimValid = 1'b1; claimReg = 5'd7;
        #2;
        chk("setwin_regwrite", 32'(RegWrite), 32'h1);
        chk("setwin_writereg", 32'(writeReg), 32'h7);
        @(negedge CLK);
        claimValid = 1'b0;
        #2;
        chk("setwin_stall_post", 32'(stall), 32'h1);
        @(negedge CLK);
        reqReg[1] = 5'd7; reqData[1] = 32'h7007; reqValid = 3'b010;
        #2;
        chk("setwin_load_ready", 32'(reqReady), 32'h2);
        @(negedge CLK);
        reqValid = 3'b000;
        #2;
        chk("setwin_stall_commit", 32'(stall), 32'h1);
        @(negedge CLK); #2;
        chk("setwin_stall_clear", 32'(stall), 32'h0);

        // Reset mid-operation with a write registered and x10 claimed (pointer at 2).
        @(negedge CLK);
        reqReg[0] = 5'd9; reqData[0] = 32'h99; reqValid = 3'b001;
        claimValid = 1'b1; claimReg = 5'd10; readReg1 = 5'd10;
        #2;
        chk("rstmid_ready", 32'(reqReady), 32'h1);
        @(negedge CLK);
        reqValid = 3'b111; claimValid = 1'b0;
        #2;
        chk("rstmid_regwrite_pre", 32'(RegWrite), 32'h1);
        chk("rstmid_stall_pre",    32'(stall),    32'h1);
        RST_n = 1'b0;
        #1;
        chk("rstmid_ready_in_rst",    32'(reqReady), 32'h0);
        chk("rstmid_regwrite_in_rst", 32'(RegWrite), 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        reqReg[0] = 5'd1; reqData[0] = 32'h111;
        #2;
        chk("rstmid_regwrite_post", 32'(RegWrite), 32'h0);
        chk("rstmid_stall_post",    32'(stall),    32'h0);
        chk("rstmid_ready_first",   32'(reqReady), 32'h1);
        @(negedge CLK);
        reqValid = 3'b000;
        #2;
        chk("rstmid_writereg", 32'(writeReg), 32'h1);
        chk("rstmid_writedata", writeData,    32'h111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
